// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage core.
//
// Watches the ID and EX stages and drives the enable, flush and bubble controls
// of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. Resolves load-use and
// flag-use stalls, taken-branch flushes, data-memory wait freezes and halt
// draining. Also keeps a saturating stall-cycle counter.
//
// Ports
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_rn_id, i_rm_id         : ID-stage source registers
//   i_use_rn_id, i_use_rm_id : ID instruction reads Rn / Rm
//   i_condbr_id, i_halt_id   : ID instruction is a conditional branch / HALT
//   i_rd_ex                  : EX-stage destination register
//   i_regwrite_ex, i_memtoreg_ex, i_flagwrite_ex : EX-stage control bits
//   i_branch_taken_ex        : pulse, branch in EX is taken
//   i_mem_wait               : data memory not ready, freeze everything
//   i_clr_cnt                : synchronous clear of o_stall_cnt
//   o_*_en                   : pipeline register enables
//   o_ifid_flush             : IF_ID loads a NOP
//   o_idex_bubble            : ID_EX loads all-zero controls
//   o_halted                 : core halted
//   o_stall_cnt              : cycles with o_pc_en=0 outside the halted state

module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [4:0]           i_rn_id,
    input  logic [4:0]           i_rm_id,
    input  logic                 i_use_rn_id,
    input  logic                 i_use_rm_id,
    input  logic                 i_condbr_id,
    input  logic                 i_halt_id,
    input  logic [4:0]           i_rd_ex,
    input  logic                 i_regwrite_ex,
    input  logic                 i_memtoreg_ex,
    input  logic                 i_flagwrite_ex,
    input  logic                 i_branch_taken_ex,
    input  logic                 i_mem_wait,
    input  logic                 i_clr_cnt,
    output logic                 o_pc_en,
    output logic                 o_ifid_en,
    output logic                 o_idex_en,
    output logic                 o_exmem_en,
    output logic                 o_memwb_en,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_pend_flush;
    logic                 w_pend_nxt;
    logic [DW-1:0]        r_drain_cnt;
    logic [DW-1:0]        w_drain_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] w_stall_nxt;

    logic w_load_use;
    logic w_flag_use;
    logic w_hazard;
    logic w_taken;

    // XZR reads as zero, so a write to it never feeds a later read.
    assign w_load_use = i_memtoreg_ex && i_regwrite_ex && (i_rd_ex != XZR) &&
                        ((i_use_rn_id && (i_rn_id == i_rd_ex)) ||
                         (i_use_rm_id && (i_rm_id == i_rd_ex)));
    assign w_flag_use = i_condbr_id && i_flagwrite_ex;
    assign w_hazard   = w_load_use || w_flag_use;
    assign w_taken    = i_branch_taken_ex || r_pend_flush;

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend_flush;
        w_drain_nxt   = r_drain_cnt;
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_idex_en     = 1'b1;
        o_exmem_en    = 1'b1;
        o_memwb_en    = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_halted      = 1'b0;

        if (!i_rst_n) begin
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_en  = 1'b0;
            o_exmem_en = 1'b0;
            o_memwb_en = 1'b0;
        end else if (r_state == StHalted) begin
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_en  = 1'b0;
            o_exmem_en = 1'b0;
            o_memwb_en = 1'b0;
            o_halted   = 1'b1;
        end else if (i_mem_wait) begin
            // Freeze; a branch resolved now must not be lost, so remember it.
            o_pc_en    = 1'b0;
            o_ifid_en  = 1'b0;
            o_idex_en  = 1'b0;
            o_exmem_en = 1'b0;
            o_memwb_en = 1'b0;
            if (i_branch_taken_ex) begin
                w_pend_nxt = 1'b1;
            end
        end else if (w_taken) begin
            // Flush discards whatever is in ID, including a HALT being drained.
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            w_pend_nxt    = 1'b0;
            w_state_nxt   = StRun;
        end else if (r_state == StDrain) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
            if (r_drain_cnt <= DW'(1)) begin
                w_drain_nxt = '0;
                w_state_nxt = StHalted;
            end else begin
                w_drain_nxt = r_drain_cnt - DW'(1);
            end
        end else if (w_hazard) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
        end else if (i_halt_id) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
            if (DRAIN_CYCLES <= 1) begin
                w_state_nxt = StHalted;
            end else begin
                w_state_nxt = StDrain;
                w_drain_nxt = DW'(DRAIN_CYCLES - 1);
            end
        end
    end

    always_comb begin
        w_stall_nxt = r_stall_cnt;
        if (i_clr_cnt) begin
            w_stall_nxt = '0;
        end else if (!o_pc_en && (r_state != StHalted) && (r_stall_cnt != '1)) begin
            w_stall_nxt = r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StRun;
            r_pend_flush <= 1'b0;
            r_drain_cnt  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_flush <= w_pend_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_stall_cnt  <= w_stall_nxt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned DC  = 3;
    localparam int unsigned CW  = 16;
    localparam int          CNT_MAX = (1 << CW) - 1;

    // Output vector order: pc, ifid, idex, exmem, memwb, flush, bubble, halted
    localparam logic [7:0] P_RUN    = 8'b11111_000;
    localparam logic [7:0] P_FLUSH  = 8'b11111_110;
    localparam logic [7:0] P_STALL  = 8'b00111_010;
    localparam logic [7:0] P_FREEZE = 8'b00000_000;
    localparam logic [7:0] P_HALT   = 8'b00000_001;

    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rn_id, rm_id, rd_ex;
    logic          use_rn, use_rm, condbr, halt_id;
    logic          regwrite, memtoreg, flagwrite, br_taken, mem_wait, clr_cnt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_bubble, halted;
    logic [CW-1:0] stall_cnt;
    logic [7:0]    obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_mode;
    bit m_pend;
    int m_left;
    int m_cnt;

    hazard_ctrl #(
        .DRAIN_CYCLES(DC),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rn_id          (rn_id),
        .i_rm_id          (rm_id),
        .i_use_rn_id      (use_rn),
        .i_use_rm_id      (use_rm),
        .i_condbr_id      (condbr),
        .i_halt_id        (halt_id),
        .i_rd_ex          (rd_ex),
        .i_regwrite_ex    (regwrite),
        .i_memtoreg_ex    (memtoreg),
        .i_flagwrite_ex   (flagwrite),
        .i_branch_taken_ex(br_taken),
        .i_mem_wait       (mem_wait),
        .i_clr_cnt        (clr_cnt),
        .o_pc_en          (pc_en),
        .o_ifid_en        (ifid_en),
        .o_idex_en        (idex_en),
        .o_exmem_en       (exmem_en),
        .o_memwb_en       (memwb_en),
        .o_ifid_flush     (ifid_flush),
        .o_idex_bubble    (idex_bubble),
        .o_halted         (halted),
        .o_stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted};

    function automatic bit model_hazard();
        bit lu;
        lu = memtoreg && regwrite && (rd_ex != 5'd31) &&
             ((use_rn && rn_id == rd_ex) || (use_rm && rm_id == rd_ex));
        return lu || (condbr && flagwrite);
    endfunction

    function automatic logic [7:0] model_exp();
        if (!rst_n)               return P_FREEZE;
        if (m_mode == M_HALTED)   return P_HALT;
        if (mem_wait)             return P_FREEZE;
        if (br_taken || m_pend)   return P_FLUSH;
        if (m_mode == M_DRAIN || model_hazard() || halt_id) return P_STALL;
        return P_RUN;
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        logic [7:0] e;
        e = model_exp();
        if (!rst_n) return;
        if (clr_cnt) m_cnt = 0;
        else if (!e[7] && m_mode != M_HALTED && m_cnt < CNT_MAX) m_cnt++;
        if (m_mode == M_HALTED) return;
        if (mem_wait) begin
            if (br_taken) m_pend = 1'b1;
        end else if (br_taken || m_pend) begin
            m_pend = 1'b0;
            m_mode = M_RUN;
        end else if (m_mode == M_DRAIN) begin
            m_left--;
            if (m_left == 0) m_mode = M_HALTED;
        end else if (!model_hazard() && halt_id) begin
            m_left = DC - 1;
            m_mode = (m_left == 0) ? M_HALTED : M_DRAIN;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rn_id = 0; rm_id = 0; rd_ex = 0; use_rn = 0; use_rm = 0; condbr = 0;
        halt_id = 0; regwrite = 0; memtoreg = 0; flagwrite = 0; br_taken = 0;
        mem_wait = 0; clr_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_mode = M_RUN; m_pend = 0; m_left = 0; m_cnt = 0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        memtoreg = 1; regwrite = 1; rd_ex = rd; use_rn = 1; rn_id = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_mode = M_RUN; m_pend = 0; m_left = 0; m_cnt = 0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (obs !== P_FREEZE || stall_cnt !== '0) begin
                $display("FAIL reset_hold cyc%0d: got %b cnt %0d, want %b cnt 0",
                         i, obs, stall_cnt, P_FREEZE);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        rst_n = 1'b1;
        tick();
        if (obs !== P_RUN || stall_cnt !== '0) begin
            $display("FAIL reset_release: got %b cnt %0d, want %b cnt 0", obs, stall_cnt, P_RUN);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        if (obs !== P_STALL) begin
            $display("FAIL load_use_stall: got %b, want %b", obs, P_STALL);
            n_fail++;
        end
        n_tests++;
        tick();
        memtoreg = 0; regwrite = 0;  // the load has moved on to MEM
        #1;
        if (obs !== P_RUN || stall_cnt !== 16'd1) begin
            $display("FAIL load_use_after: got %b cnt %0d, want %b cnt 1", obs, stall_cnt, P_RUN);
            n_fail++;
        end
        n_tests++;
        tick();
        set_load_use(5'd31);
        #1;
        if (obs !== P_RUN) begin
            $display("FAIL load_use_xzr: got %b, want %b", obs, P_RUN);
            n_fail++;
        end
        n_tests++;
        tick();
        if (stall_cnt !== 16'd1) begin
            $display("FAIL load_use_xzr_cnt: got %0d, want 1", stall_cnt);
            n_fail++;
        end
        n_tests++;
        idle_inputs();
        // flag-use hazard
        condbr = 1; flagwrite = 1;
        #1;
        if (obs !== P_STALL) begin
            $display("FAIL flag_use_stall: got %b, want %b", obs, P_STALL);
            n_fail++;
        end
        n_tests++;
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_freeze();
        logic [7:0] want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            mem_wait = (c < 4);
            br_taken = (c == 0);
            #1;
            want = (c < 4) ? P_FREEZE : ((c == 4) ? P_FLUSH : P_RUN);
            if (obs !== want) begin
                $display("FAIL branch_freeze cyc%0d: got %b, want %b", c, obs, want);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        if (stall_cnt !== 16'd4) begin
            $display("FAIL branch_freeze_cnt: got %0d, want 4", stall_cnt);
            n_fail++;
        end
        n_tests++;
        idle_inputs();
    endtask

    task automatic test_branch_vs_hazards();
        do_reset();
        set_load_use(5'd7);
        br_taken = 1;
        #1;
        if (obs !== P_FLUSH) begin
            $display("FAIL branch_vs_loaduse: got %b, want %b", obs, P_FLUSH);
            n_fail++;
        end
        n_tests++;
        tick();
        if (stall_cnt !== 16'd0) begin
            $display("FAIL branch_vs_loaduse_cnt: got %0d, want 0", stall_cnt);
            n_fail++;
        end
        n_tests++;
        idle_inputs();
        halt_id = 1; br_taken = 1;
        #1;
        if (obs !== P_FLUSH) begin
            $display("FAIL branch_vs_halt: got %b, want %b", obs, P_FLUSH);
            n_fail++;
        end
        n_tests++;
        tick();
        idle_inputs();
        #1;
        if (obs !== P_RUN) begin
            $display("FAIL branch_vs_halt_after: got %b, want %b", obs, P_RUN);
            n_fail++;
        end
        n_tests++;
    endtask

    // wait_at lists cycles (relative to the halt) that see mem_wait
    task automatic run_halt(input int w0, input int w1, input int halt_cyc, input string tag);
        logic [7:0] want;
        do_reset();
        for (int c = 0; c <= halt_cyc + 1; c++) begin
            halt_id  = 1;  // HALT sits in ID while IF_ID is held
            mem_wait = (c == w0) || (c == w1);
            #1;
            if (c >= halt_cyc)  want = P_HALT;
            else if (mem_wait)  want = P_FREEZE;
            else                want = P_STALL;
            if (obs !== want) begin
                $display("FAIL %s cyc%0d: got %b, want %b", tag, c, obs, want);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        run_halt(-1, -1, DC, "halt");
        run_halt(1, 2, DC + 2, "halt_wait");
        if (stall_cnt !== 16'(DC + 2)) begin
            $display("FAIL halt_cnt: got %0d, want %0d", stall_cnt, DC + 2);
            n_fail++;
        end
        n_tests++;
        rst_n = 0;
        #1;
        if (halted !== 1'b0 || obs !== P_FREEZE) begin
            $display("FAIL halt_reset: got %b, want %b", obs, P_FREEZE);
            n_fail++;
        end
        n_tests++;
        do_reset();
        if (obs !== P_RUN) begin
            $display("FAIL halt_reset_release: got %b, want %b", obs, P_RUN);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_random();
        int since_reset;
        do_reset();
        since_reset = 0;
        for (int c = 0; c < 1500; c++) begin
            rn_id    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            rm_id    = 5'($urandom_range(0, 3));
            rd_ex    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            use_rn   = 1'($urandom_range(0, 1));
            use_rm   = 1'($urandom_range(0, 1));
            condbr   = ($urandom_range(0, 4) == 0);
            halt_id  = ($urandom_range(0, 19) == 0);
            regwrite = 1'($urandom_range(0, 1));
            memtoreg = ($urandom_range(0, 2) == 0);
            flagwrite = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 9) == 0);
            mem_wait = ($urandom_range(0, 4) == 0);
            clr_cnt  = ($urandom_range(0, 39) == 0);
            #1;
            if (obs !== model_exp()) begin
                $display("FAIL random_out cyc%0d: got %b, want %b", c, obs, model_exp());
                n_fail++;
            end
            n_tests++;
            if (stall_cnt !== CW'(m_cnt)) begin
                $display("FAIL random_cnt cyc%0d: got %0d, want %0d", c, stall_cnt, m_cnt);
                n_fail++;
            end
            n_tests++;
            tick();
            since_reset++;
            if (since_reset > 60 || (m_mode == M_HALTED && $urandom_range(0, 3) == 0)) begin
                do_reset();
                since_reset = 0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter_sat();
        do_reset();
        set_load_use(5'd3);
        repeat (65540) tick();
        if (stall_cnt !== 16'hFFFF || m_cnt != CNT_MAX) begin
            $display("FAIL counter_sat: got %h, want ffff", stall_cnt);
            n_fail++;
        end
        n_tests++;
        clr_cnt = 1;  // stall still active: clear must win
        #1;
        tick();
        clr_cnt = 0;
        #1;
        if (stall_cnt !== 16'h0000) begin
            $display("FAIL counter_clr: got %h, want 0000", stall_cnt);
            n_fail++;
        end
        n_tests++;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_branch_freeze();
        test_branch_vs_hazards();
        test_halt();
        test_random();
        test_counter_sat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It watches the ID and EX stages and drives the enable, flush and bubble inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves load-use and flag-use stalls, taken-branch flushes, data-memory wait freezes, and halt draining, and keeps a saturating stall-cycle performance counter.

## Interface
- DRAIN_CYCLES, 3: cycles needed to retire EX, MEM and WB after a halt in ID.
- CNT_WIDTH, 16: width of the stall counter.

- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- Rn_id, Rm_id  in  5 each  ID-stage source register numbers.
- use_rn_id, use_rm_id  in  1 each  ID instruction reads Rn / Rm.
- condbr_id  in  1  ID instruction is a conditional branch (reads flags).
- halt_id  in  1  ID instruction is HALT.
- Rd_ex  in  5  EX-stage destination register.
- RegWrite_ex, MemToReg_ex, flagWrite_ex  in  1 each  EX-stage control bits.
- branch_taken_ex  in  1  single-cycle pulse: the branch in EX is taken.
- mem_wait  in  1  data memory not ready; the whole pipeline must freeze.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush  out  1  IF_ID loads a NOP.
- idex_bubble  out  1  ID_EX loads all-zero controls.
- halted  out  1  core halted.
- stall_cnt  out  CNT_WIDTH  cycles with pc_en=0 outside HALTED.

## Operation
- State: FSM {RUN, DRAIN, HALTED}, pend_flush flag, drain counter (DRAIN_CYCLES range), stall_cnt.
- Outputs are combinational from state and inputs.
- Default (RUN, no event): all enables are 1; ifid_flush=0; idex_bubble=0.
- Register 31 (XZR) never creates a hazard.
- Load-use: MemToReg_ex & RegWrite_ex & Rd_ex≠31 & ((use_rn_id & Rn_id==Rd_ex) | (use_rm_id & Rm_id==Rd_ex)).
- Flag-use: condbr_id & flagWrite_ex.
- Event priority, highest first:
  1. mem_wait=1: all five enables 0, ifid_flush=0, idex_bubble=0. A branch_taken_ex pulse sets pend_flush.
  2. Flush: taken = branch_taken_ex | pend_flush. Drive ifid_flush=1 and idex_bubble=1 with all enables 1 (PC loads the target). Clear pend_flush. An instruction in ID (including HALT) is discarded; state stays or returns to RUN.
  3. Load-use or flag-use stall: pc_en=0, ifid_en=0, idex_bubble=1, rest enabled. This inserts exactly one bubble; the hazard clears next cycle as EX advances.
  4. halt_id in RUN: pc_en=0, ifid_en=0, idex_bubble=1. Go to DRAIN and load the counter with DRAIN_CYCLES-1.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_bubble=1; downstream stages enabled.
  - The counter decrements each non-mem_wait cycle. At 0, go to HALTED.
  - mem_wait freezes the counter.
- HALTED: all enables 0, halted=1. Only reset exits.
- stall_cnt:
  - Increments when pc_en=0, state≠HALTED and reset is high.
  - Saturates at all-ones.
  - clr_cnt has priority over increment.

## Timing
- reset low (asynchronous): state=RUN, pend_flush=0, drain counter=0, stall_cnt=0. While reset is low, all enables=0, ifid_flush=0, idex_bubble=0, halted=0.
- First edge after reset rises: normal RUN behaviour.
- Stall, flush and freeze responses are zero-latency: they are asserted in the same cycle as the triggering input.
- A pending flush is applied in the first cycle with mem_wait=0, then cleared.
- Halt latency: halt_id seen at cycle N gives halted=1 at cycle N+DRAIN_CYCLES, plus any mem_wait cycles.
- Simultaneous events:
  - Branch and load-use in the same cycle: the flush wins and no stall is inserted.
  - Branch and halt_id in the same cycle: no halt.
  - mem_wait and branch in the same cycle: freeze, with pend_flush set.

## Test plan
- Reset release: hold reset=0 for 3 cycles → all outputs 0. Release → pc_en=1 on the next cycle, stall_cnt=0.
- Load-use: EX holds LDUR X5 (MemToReg=1, RegWrite=1, Rd=5); ID has ADD with Rn=5 → one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then normal flow; stall_cnt=1. Repeat with Rd=31 → no stall.
- Branch under freeze: branch_taken_ex pulses while mem_wait=1 for 4 cycles → enables 0 for 4 cycles, then ifid_flush=1 and idex_bubble=1 on cycle 5, then normal flow.
- Branch vs load-use: both in the same cycle → flush only; pc_en=1 and stall_cnt unchanged.
- Halt: halt_id at cycle 10 → idex_bubble=1 for cycles 10–12 and halted=1 at cycle 13. A 2-cycle mem_wait inside the drain moves halted=1 to cycle 15. Reset clears halted.
- Counter: force 65,540 stall cycles → stall_cnt=0xFFFF. clr_cnt=1 → 0 next cycle.
